// File: rtl/count_seq_checker.sv
// Monitor for a free-running binary counter stream: locks after a run of +1 steps,
// then pulses and counts sequence errors, dropping lock after repeated consecutive errors.
module count_seq_checker #(
  parameter int WIDTH       = 3,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] cont_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERRS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_expected;
  logic [3:0]       r_good_run;
  logic [3:0]       r_bad_run;
  logic [3:0]       w_good_run_nxt;
  logic [3:0]       w_bad_run_nxt;
  logic [3:0]       w_good_inc;
  logic [3:0]       w_bad_inc;
  logic             w_step_ok;
  logic             w_err;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;
  logic             w_err_sat;

  assign w_step_ok  = (cont_in == WIDTH'(r_prev + WIDTH'(1)));
  assign w_good_inc = r_good_run + 4'd1;
  assign w_bad_inc  = r_bad_run + 4'd1;
  assign w_err_sat  = &r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid) begin
      case (r_state)
        IDLE:    w_state_nxt = ACQ;
        ACQ:     if (w_step_ok && (w_good_inc == LOCK_C)) w_state_nxt = LOCKED;
        LOCKED:  if (!w_step_ok && (w_bad_inc == UNLOCK_C)) w_state_nxt = ACQ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Run counters are cleared on every state change so neither exceeds its threshold.
  always_comb begin
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;
    w_err          = 1'b0;
    if (valid) begin
      case (r_state)
        IDLE: w_good_run_nxt = '0;
        ACQ: begin
          if (!w_step_ok) begin
            w_good_run_nxt = '0;
          end else if (w_good_inc == LOCK_C) begin
            w_good_run_nxt = '0;
            w_bad_run_nxt  = '0;
          end else begin
            w_good_run_nxt = w_good_inc;
          end
        end
        LOCKED: begin
          if (w_step_ok) begin
            w_bad_run_nxt = '0;
          end else begin
            w_err = 1'b1;
            if (w_bad_inc == UNLOCK_C) begin
              w_bad_run_nxt  = '0;
              w_good_run_nxt = '0;
            end else begin
              w_bad_run_nxt = w_bad_inc;
            end
          end
        end
        default: begin
          w_good_run_nxt = '0;
          w_bad_run_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_expected  <= '0;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_good_run  <= w_good_run_nxt;
      r_bad_run   <= w_bad_run_nxt;
      r_err_pulse <= w_err;
      if (valid) begin
        r_prev     <= cont_in;
        r_expected <= cont_in + WIDTH'(1);
      end
      // A clear coinciding with a counted error keeps that error.
      if (clear)
        r_err_count <= w_err ? ERR_W'(1) : '0;
      else if (w_err && !w_err_sat)
        r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a default instance plus an ERR_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_count_seq_checker;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [2:0] cont_in;
  logic       clear;
  logic       locked, err_pulse;
  logic [7:0] err_count;
  logic [2:0] expected;
  logic       locked2, err_pulse2;
  logic [1:0] err_count2;
  logic [2:0] expected2;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  count_seq_checker #(.WIDTH(3), .LOCK_CNT(4), .UNLOCK_ERRS(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .cont_in(cont_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  count_seq_checker #(.WIDTH(3), .LOCK_CNT(4), .UNLOCK_ERRS(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid(valid), .cont_in(cont_in), .clear(clear),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .expected(expected2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] d, input logic c);
    @(negedge clk);
    valid   = v;
    cont_in = d;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; cont_in = '0; clear = 1'b0;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_count", err_count, 0);
    chk("rst_expected", expected, 0);
    @(negedge clk);
    rst = 1'b0;

    // lock acquisition
    step(1, 3'd0, 0);
    chk("acq_idle_nolock", locked, 0);
    step(1, 3'd1, 0);
    step(1, 3'd2, 0);
    step(1, 3'd3, 0);
    chk("acq_3_nolock", locked, 0);
    step(1, 3'd4, 0);
    chk("lock_locked", locked, 1);
    chk("lock_count", err_count, 0);
    chk("lock_expected", expected, 5);

    // wrap-around
    step(1, 3'd5, 0);
    step(1, 3'd6, 0);
    step(1, 3'd7, 0);
    chk("wrap_7_pulse", err_pulse, 0);
    step(1, 3'd0, 0);
    chk("wrap_0_pulse", err_pulse, 0);
    chk("wrap_0_expected", expected, 1);
    step(1, 3'd1, 0);
    chk("wrap_locked", locked, 1);
    chk("wrap_expected", expected, 2);

    // single glitch
    step(1, 3'd2, 0);
    step(1, 3'd3, 0);
    step(1, 3'd5, 0);
    chk("glitch_pulse", err_pulse, 1);
    chk("glitch_count", err_count, 1);
    chk("glitch_locked", locked, 1);
    chk("glitch_count2", err_count2, 1);
    step(1, 3'd6, 0);
    chk("glitch_pulse_once", err_pulse, 0);
    chk("glitch_expected", expected, 7);
    step(1, 3'd7, 0);
    step(1, 3'd3, 0);
    chk("badrun_reset_locked", locked, 1);
    chk("badrun_reset_count", err_count, 2);
    step(1, 3'd4, 0);

    // loss of lock
    step(1, 3'd5, 0);
    step(1, 3'd6, 0);
    step(1, 3'd1, 0);
    chk("loss_pulse1", err_pulse, 1);
    chk("loss_locked1", locked, 1);
    chk("loss_count2sat", err_count2, 3);
    step(1, 3'd5, 0);
    chk("loss_pulse2", err_pulse, 1);
    chk("loss_count", err_count, 4);
    chk("loss_unlocked", locked, 0);
    chk("loss_count2hold", err_count2, 3);
    step(1, 3'd0, 0);
    chk("acq_bad_pulse", err_pulse, 0);
    chk("acq_bad_count", err_count, 4);
    step(1, 3'd1, 0);
    step(1, 3'd2, 0);
    step(1, 3'd3, 0);
    chk("relock_early", locked, 0);
    step(1, 3'd4, 0);
    chk("relock", locked, 1);

    // valid gaps
    step(1, 3'd5, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd2, 0);
      chk("gap_pulse", err_pulse, 0);
      chk("gap_expected", expected, 6);
    end
    step(1, 3'd6, 0);
    chk("gap_after_pulse", err_pulse, 0);
    chk("gap_after_locked", locked, 1);
    chk("gap_after_count", err_count, 4);

    // fifth error, then clear interactions
    step(1, 3'd3, 0);
    chk("err5_count", err_count, 5);
    chk("err5_count2", err_count2, 3);
    step(1, 3'd4, 0);
    step(1, 3'd0, 1);
    chk("clear_err_pulse", err_pulse, 1);
    chk("clear_err_count", err_count, 1);
    chk("clear_err_count2", err_count2, 1);
    step(1, 3'd1, 0);
    chk("post_clear_count", err_count, 1);
    step(0, 3'd0, 1);
    chk("clear_only_count", err_count, 0);
    chk("clear_only_count2", err_count2, 0);
    chk("clear_only_locked", locked, 1);

    // async reset mid-cycle
    step(1, 3'd5, 0);
    step(1, 3'd6, 0);
    chk("pre_rst_count", err_count, 1);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_expected", expected, 7);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_locked", locked, 0);
    chk("async_count", err_count, 0);
    chk("async_expected", expected, 0);
    chk("async_count2", err_count2, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 3'd0, 0);
    chk("post_rst_locked", locked, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receiving end for the 3-bit binary counter stream.
- Samples the count value on each cycle it is marked valid and verifies that every sample is the previous sample plus one, modulo 2^WIDTH.
- Acquires lock after a run of correct steps, then flags and counts sequence errors.
- Drops lock after repeated consecutive errors. Used as an on-chip monitor next to the counter.

Parameters:
- WIDTH, 3: width of monitored count.
- LOCK_CNT, 4: consecutive correct steps required to enter LOCKED (range 1..15).
- UNLOCK_ERRS, 2: consecutive errors while LOCKED that force re-acquisition (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid  input  1  cont_in is sampled this cycle.
- cont_in  input  WIDTH  count value from the counter.
- clear  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected error.
- err_count  output  ERR_W  saturating error total.
- expected  output  WIDTH  next value the checker expects; equals prev+1 mod 2^WIDTH.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - FSM goes to IDLE; locked=0, err_pulse=0, err_count=0, expected=0.
  - Internal prev, good_run and bad_run all = 0.
  - Effect is immediate, not waiting for a clock edge.
- Outputs: all registered; responses appear on the clock edge that samples the stimulus.
- A step is "good" when valid=1 and cont_in == (prev+1) mod 2^WIDTH.
  - Wrap 7->0 (WIDTH=3) is good.
  - Any other value, including a repeat, is bad.
- valid=0: FSM, prev, good_run, bad_run and err_count hold (clear still acts); err_pulse=0.
- Every valid sample loads prev<=cont_in in all states, so the checker resynchronises to the received value.
- FSM transitions:
  - IDLE: on valid, capture prev, good_run=0, go to ACQ. No error is possible.
  - ACQ, good step: good_run+1. If that value equals LOCK_CNT, go to LOCKED, locked=1, bad_run=0.
  - ACQ, bad step: good_run=0, stay in ACQ. No err_pulse and no err_count change (errors are counted only while locked).
  - LOCKED, good step: bad_run=0.
  - LOCKED, bad step: err_pulse=1 for exactly one cycle; err_count+1, saturating at 2^ERR_W-1; bad_run+1.
  - LOCKED, bad_run reaches UNLOCK_ERRS: go to ACQ, locked=0, good_run=0. The err_pulse for that error is still issued.
- Counters: good_run and bad_run are 4 bits and never exceed their thresholds.
- clear:
  - clear=1 sets err_count=0 next edge.
  - clear and a counted error on the same edge give err_count=1 (the error is not lost).
- expected is updated with prev on every valid sample.

Test Plan:
- Lock acquisition:
  - Stimulus: rst pulse, then valid=1 with 0,1,2,3,4 on consecutive edges.
  - Response: locked=1 after the edge sampling 4, err_count=0, expected=5.
- Wrap-around:
  - Stimulus: locked, stream 6,7,0,1.
  - Response: no err_pulse, locked stays 1, expected=2.
- Single glitch:
  - Stimulus: locked, stream 2,3,5,6.
  - Response: err_pulse high for one cycle after sample 5, err_count=1, locked stays 1. 5->6 is good, so bad_run returns to 0.
- Loss of lock:
  - Stimulus: locked, stream 1,2,5,1.
  - Response: two err_pulses, err_count=2, locked=0 after sample 1.
  - Follow-up: 2,3,4,5 relocks.
  - Check: a bad value during ACQ gives no pulse.
- Saturation and clear:
  - Stimulus: ERR_W=2, 5 counted errors.
  - Response: err_count=3 (saturated).
  - Then: clear with simultaneous error gives err_count=1; clear alone gives 0.
- Valid gaps and async reset:
  - Stimulus: locked, valid low for 3 cycles between samples 3 and 4.
  - Response: no error.
  - Then: rst asserted mid-cycle; locked, err_count and expected read 0 before the next clk edge.
